alu_cmd_ctrl: RTL and testbench
===============================

// Module: alu_cmd_ctrl
// PURPOSE
//  Upstream command stage for the 16-bit unsigned ALU. Accepts one operation per
//  valid/ready handshake and drives the ALU's A, B and ALU_FUN inputs. Waits out the
//  ALU's registered latency, then captures ALU_OUT plus the five flags into a held
//  response with its own valid/ready handshake. One operation is in flight at a time.
// PARAMETERS
//  WIDTH    16  operand/result width; must match the ALU
//  ALU_LAT  1   ALU clock latency, inputs to ALU_OUT/flags; legal range 1..4
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command
//  cmd_fun    in   4      ALU_FUN code for the command
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  alu_a      out  WIDTH  to ALU A
//  alu_b      out  WIDTH  to ALU B
//  alu_fun    out  4      to ALU ALU_FUN
//  alu_out    in   WIDTH  from ALU ALU_OUT
//  alu_flags  in   5      from ALU: {carry,arith,logic,cmp,shift}
//  rsp_valid  out  1      response held
//  rsp_ready  in   1      consumer takes response
//  rsp_data   out  WIDTH  captured ALU_OUT
//  rsp_flags  out  5      captured flags, same bit order as alu_flags
//  rsp_err    out  1      command rejected; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0.
//    alu_a=alu_b=0, alu_fun=4'b1111 (NOP), rsp_data=0, rsp_flags=0, cnt=0.
//  - All outputs are registered. No combinational path from any input to any output.
//  - FSM IDLE: cmd_ready=1. When cmd_valid=1 at edge T0, register cmd_* into alu_*,
//    load cnt=ALU_LAT, go WAIT. cmd_ready drops after T0.
//  - FSM WAIT: alu_* held stable. cnt decrements by 1 per edge. At the edge where
//    cnt==0 (edge T0+ALU_LAT+1): capture alu_out->rsp_data, alu_flags->rsp_flags,
//    set rsp_valid=1, drive alu_fun back to NOP, go RESP.
//  - Latency: rsp_valid rises ALU_LAT+1 cycles after the accepting edge.
//  - FSM RESP: rsp_data, rsp_flags and rsp_err are held unchanged while rsp_valid=1
//    and rsp_ready=0. At an edge with rsp_ready=1: rsp_valid=0, go IDLE.
//  - cmd_ready is 1 only in IDLE. A command offered in WAIT or RESP is not taken and
//    must stay asserted by the source. Minimum issue interval is ALU_LAT+3 cycles.
//  - cmd_fun is passed through unchanged, including unused codes (1111 -> NOP).
//    Operands and results are unsigned WIDTH bits. The ALU's carry/borrow is reported
//    only through rsp_flags[4]; no extra width is added.
//  - rst asserted in any state: the in-flight operation is discarded immediately and
//    no response is issued for it. All state returns to reset values.
//  - rsp_ready=1 while in IDLE or WAIT has no effect.
// CONFIGURATION
//  ALU_CMD_DIV0_CHK_EN defined: a command with cmd_fun==4'b0011 and cmd_b==0 is
//    accepted but not issued. alu_* stay at their idle values. The next edge goes
//    directly to RESP with rsp_data={WIDTH{1'b1}}, rsp_flags=5'b01000 and rsp_err=1
//    (latency 1 cycle). All other commands give rsp_err=0.
//  ALU_CMD_DIV0_CHK_EN undefined: no check is made, every command is issued to the
//    ALU, and rsp_err is tied to 0.
// TESTING
//  1 Reset: rst pulse mid-cycle -> cmd_ready=1, rsp_valid=0, alu_fun=1111, all data 0.
//  2 Add: fun=0000, A=0x1752, B=0x0B7C -> rsp_data=0x22CE, rsp_flags=01000.
//    Check rsp_valid rises exactly ALU_LAT+1 cycles after accept.
//  3 Add with carry: A=0xD752, B=0x8B7C -> rsp_data=0x62CE, rsp_flags=11000.
//    Then sub, A=0x1234, B=0x5678 -> rsp_data=0xBBBC, rsp_flags=11000.
//  4 Backpressure: hold rsp_ready=0 for 6 cycles after a response with AND
//    (0x0064 & 0x0032 -> 0x0020, flags 00100). Response stays stable, cmd_ready=0,
//    and a pending cmd_valid is not taken until one cycle after release.
//  5 Reset mid-WAIT: assert rst one cycle after accept -> no rsp_valid pulse.
//    The next command, 0x0232 > 0x0032 (fun=1011), gives 0x0002, flags 00010.
//  6 Div by zero, fun=0011, A=100, B=0:
//    with the macro -> rsp_data=0xFFFF, rsp_err=1, flags 01000, 1-cycle latency.
//    without the macro -> the command is issued to the ALU and rsp_err=0.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// Command/response front end for the 16-bit ALU: one operation in flight, registered outputs.
// Optional divide-by-zero rejection is enabled by defining ALU_CMD_DIV0_CHK_EN.
module alu_cmd_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_fun,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [4:0]       rsp_flags,
    output logic             rsp_err,
    output logic [1:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a source holds valid and its payload stable until that edge.

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    localparam logic [3:0] FUN_NOP = 4'b1111;
    localparam logic [3:0] FUN_DIV = 4'b0011;

    logic [1:0] state;
    logic [2:0] cnt;
    logic       div0_q;
    logic       div0_cmd;

`ifdef ALU_CMD_DIV0_CHK_EN
    assign div0_cmd = (cmd_fun == FUN_DIV) && (cmd_b == '0);
`else
    assign div0_cmd = 1'b0;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div0_q    <= 1'b0;
            cmd_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= FUN_NOP;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        state     <= S_WAIT;
                        if (div0_cmd) begin
                            // Rejected command: ALU untouched, response on the next edge.
                            div0_q <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            div0_q  <= 1'b0;
                            alu_a   <= cmd_a;
                            alu_b   <= cmd_b;
                            alu_fun <= cmd_fun;
                            cnt     <= 3'(ALU_LAT);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        alu_fun   <= FUN_NOP;
                        rsp_err   <= div0_q;
                        if (div0_q) begin
                            rsp_data  <= '1;
                            rsp_flags <= 5'b01000;
                        end else begin
                            rsp_data  <= alu_out;
                            rsp_flags <= alu_flags;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered 16-bit ALU stand-in of ALU_LAT stages.
// Expectations follow ALU_CMD_DIV0_CHK_EN when it is defined for the build.
module tb_alu_cmd_ctrl;

    localparam int WIDTH = 16;
    localparam int LAT   = 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_fun = 4'b0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] alu_out;
    logic [4:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic [4:0]       rsp_flags;
    logic             rsp_err;
    logic [1:0]       fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_ctrl #(.WIDTH(WIDTH), .ALU_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_fun   (cmd_fun),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .fsm_state (fsm_state)
    );

    // ALU stand-in: result {flags, data}, flags = {carry, arith, logic, cmp, shift}.
    function automatic logic [20:0] alu_model(input logic [3:0] f, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  fl;
        s  = '0;
        r  = '0;
        fl = '0;
        case (f)
            4'd0:  begin s = a + b; r = s[15:0]; fl = {s[16], 4'b1000}; end
            4'd1:  begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; fl = {s[16], 4'b1000}; end
            4'd2:  begin r = a * b; fl = 5'b01000; end
            4'd3:  begin r = (b == 16'd0) ? 16'd0 : a / b; fl = 5'b01000; end
            4'd4:  begin r = a & b;    fl = 5'b00100; end
            4'd5:  begin r = a | b;    fl = 5'b00100; end
            4'd6:  begin r = ~(a & b); fl = 5'b00100; end
            4'd7:  begin r = ~(a | b); fl = 5'b00100; end
            4'd8:  begin r = a ^ b;    fl = 5'b00100; end
            4'd9:  begin r = ~(a ^ b); fl = 5'b00100; end
            4'd10: begin r = (a == b) ? 16'd1 : 16'd0; fl = 5'b00010; end
            4'd11: begin r = (a > b)  ? 16'd2 : 16'd0; fl = 5'b00010; end
            4'd12: begin r = (a < b)  ? 16'd3 : 16'd0; fl = 5'b00010; end
            4'd13: begin r = a >> 1; fl = 5'b00001; end
            4'd14: begin r = a << 1; fl = 5'b00001; end
            default: begin r = '0; fl = '0; end
        endcase
        return {fl, r};
    endfunction

    logic [20:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= alu_model(alu_fun, alu_a, alu_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign {alu_flags, alu_out} = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge right after the accepting edge.
    task automatic send(input string tag, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b);
        logic ok;
        int   n;
        cmd_fun   = f;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            ok = cmd_ready;
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check({tag, " accept"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat, input logic [15:0] exp_data,
                            input logic [4:0] exp_flags, input logic exp_err);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, " flags"}, 32'(rsp_flags), 32'(exp_flags));
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " nop"}, 32'(alu_fun), 32'hF);
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " released"}, 32'(rsp_valid), 32'd0);
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int pulses;

        repeat (2) @(negedge clk);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst alu_fun", 32'(alu_fun), 32'hF);
        check("rst alu_a", 32'(alu_a), 32'd0);
        check("rst rsp_data", 32'(rsp_data), 32'd0);
        check("rst state", 32'(fsm_state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Plain add, with the ALU drive checked while waiting.
        send("add", 4'b0000, 16'h1752, 16'h0B7C);
        check("add alu_a", 32'(alu_a), 32'h1752);
        check("add alu_b", 32'(alu_b), 32'h0B7C);
        check("add alu_fun", 32'(alu_fun), 32'h0);
        check("add state", 32'(fsm_state), 32'(S_WAIT));
        check("add cmd_ready", 32'(cmd_ready), 32'd0);
        wait_rsp("add", LAT + 1, 16'h22CE, 5'b01000, 1'b0);
        check("add state resp", 32'(fsm_state), 32'(S_RESP));
        take_rsp("add");

        send("addc", 4'b0000, 16'hD752, 16'h8B7C);
        wait_rsp("addc", LAT + 1, 16'h62CE, 5'b11000, 1'b0);
        take_rsp("addc");

        send("sub", 4'b0001, 16'h1234, 16'h5678);
        wait_rsp("sub", LAT + 1, 16'hBBBC, 5'b11000, 1'b0);
        take_rsp("sub");

        // Backpressure with a pending command behind the held response.
        send("and", 4'b0100, 16'h0064, 16'h0032);
        wait_rsp("and", LAT + 1, 16'h0020, 5'b00100, 1'b0);
        cmd_fun   = 4'b0000;
        cmd_a     = 16'h0001;
        cmd_b     = 16'h0002;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp valid", 32'(rsp_valid), 32'd1);
            check("bp data", 32'(rsp_data), 32'h0020);
            check("bp flags", 32'(rsp_flags), 32'h04);
            check("bp cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp release valid", 32'(rsp_valid), 32'd0);
        check("bp release state", 32'(fsm_state), 32'(S_IDLE));
        check("bp release ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp pending taken", 32'(fsm_state), 32'(S_WAIT));
        check("bp pending alu_b", 32'(alu_b), 32'h0002);
        wait_rsp("bp pending", LAT + 1, 16'h0003, 5'b01000, 1'b0);
        take_rsp("bp pending");

        // rsp_ready while idle is ignored.
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle rsp_ready valid", 32'(rsp_valid), 32'd0);
        check("idle rsp_ready state", 32'(fsm_state), 32'(S_IDLE));

        // Reset one cycle after accept: the operation vanishes.
        send("rstwait", 4'b0000, 16'h1111, 16'h2222);
        rst = 1'b1;
        #1;
        check("rstwait state", 32'(fsm_state), 32'(S_IDLE));
        check("rstwait alu_fun", 32'(alu_fun), 32'hF);
        check("rstwait cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rstwait no response", 32'(pulses), 32'd0);
        send("gt", 4'b1011, 16'h0232, 16'h0032);
        wait_rsp("gt", LAT + 1, 16'h0002, 5'b00010, 1'b0);
        take_rsp("gt");

        // Mid-cycle asynchronous reset while a response is held.
        send("xor", 4'b1000, 16'h00FF, 16'h0F0F);
        wait_rsp("xor", LAT + 1, 16'h0FF0, 5'b00100, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("async rst valid", 32'(rsp_valid), 32'd0);
        check("async rst data", 32'(rsp_data), 32'd0);
        check("async rst flags", 32'(rsp_flags), 32'd0);
        check("async rst alu_a", 32'(alu_a), 32'd0);
        check("async rst ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Divide by zero.
        send("div0", 4'b0011, 16'd100, 16'd0);
`ifdef ALU_CMD_DIV0_CHK_EN
        check("div0 alu_fun", 32'(alu_fun), 32'hF);
        wait_rsp("div0", 1, 16'hFFFF, 5'b01000, 1'b1);
`else
        check("div0 alu_fun", 32'(alu_fun), 32'h3);
        check("div0 alu_b", 32'(alu_b), 32'd0);
        wait_rsp("div0", LAT + 1, 16'h0000, 5'b01000, 1'b0);
`endif
        take_rsp("div0");

        send("div", 4'b0011, 16'd100, 16'd7);
        wait_rsp("div", LAT + 1, 16'h000E, 5'b01000, 1'b0);
        take_rsp("div");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
